// File: rtl/mac_pipe_acc.sv
// Two-stage multi-channel multiply-add / accumulate unit with valid/ready flow control.
// Define SATURATE_EN to clamp overflowing results to all-ones instead of wrapping.
module mac_pipe_acc #(
    parameter int IN_W     = 8,
    parameter int OUT_W    = 16,
    parameter int CHANNELS = 4,
    localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CH_W-1:0]  in_ch,
    input  logic             in_mode,
    input  logic             in_clr,
    input  logic [IN_W-1:0]  A,
    input  logic [IN_W-1:0]  B,
    input  logic [OUT_W-1:0] C,
    input  logic             acc_clr_all,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CH_W-1:0]  out_ch,
    output logic [OUT_W-1:0] data_out,
    output logic             out_ovf
);

    logic en;

    logic             s1_valid_q, s1_valid_d;
    logic [OUT_W-1:0] s1_prod_q,  s1_prod_d;
    logic [OUT_W-1:0] s1_c_q,     s1_c_d;
    logic [CH_W-1:0]  s1_ch_q,    s1_ch_d;
    logic             s1_mode_q,  s1_mode_d;
    logic             s1_clr_q,   s1_clr_d;

    logic             out_valid_q;
    logic [OUT_W-1:0] data_q;
    logic [CH_W-1:0]  out_ch_q;
    logic             out_ovf_q;

    logic [OUT_W-1:0] acc_q [CHANNELS];

    logic [2*IN_W-1:0] mul;
    logic [OUT_W-1:0]  addend;
    logic [OUT_W:0]    sum;
    logic [OUT_W-1:0]  res;
    logic              acc_we;

    assign en       = !out_valid_q || out_ready;
    assign in_ready = en && !reset;

    assign out_valid = out_valid_q;
    assign data_out  = data_q;
    assign out_ch    = out_ch_q;
    assign out_ovf   = out_ovf_q;

    assign mul = (2*IN_W)'(A) * (2*IN_W)'(B);

    // Out-of-range channel indices fold onto channel 0.
    always_comb begin
        s1_valid_d = in_valid && in_ready;
        s1_prod_d  = OUT_W'(mul);
        s1_c_d     = C;
        s1_mode_d  = in_mode;
        s1_clr_d   = in_clr;
        s1_ch_d    = in_ch;
        if ({1'b0, in_ch} >= (CH_W+1)'(CHANNELS)) begin
            s1_ch_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_prod_q  <= '0;
            s1_c_q     <= '0;
            s1_ch_q    <= '0;
            s1_mode_q  <= 1'b0;
            s1_clr_q   <= 1'b0;
        end else if (en) begin
            s1_valid_q <= s1_valid_d;
            s1_prod_q  <= s1_prod_d;
            s1_c_q     <= s1_c_d;
            s1_ch_q    <= s1_ch_d;
            s1_mode_q  <= s1_mode_d;
            s1_clr_q   <= s1_clr_d;
        end
    end

    always_comb begin
        addend = s1_c_q;
        if (s1_mode_q) begin
            addend = s1_clr_q ? '0 : acc_q[s1_ch_q];
        end
        sum = {1'b0, s1_prod_q} + {1'b0, addend};
`ifdef SATURATE_EN
        res = sum[OUT_W] ? '1 : sum[OUT_W-1:0];
`else
        res = sum[OUT_W-1:0];
`endif
    end

    assign acc_we = en && s1_valid_q && s1_mode_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            data_q      <= '0;
            out_ch_q    <= '0;
            out_ovf_q   <= 1'b0;
        end else if (en) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                data_q    <= res;
                out_ch_q  <= s1_ch_q;
                out_ovf_q <= sum[OUT_W];
            end
        end
    end

    // A global clear beats a same-edge accumulate write.
    always_ff @(posedge clk) begin
        if (reset || acc_clr_all) begin
            for (int i = 0; i < CHANNELS; i++) begin
                acc_q[i] <= '0;
            end
        end else if (acc_we) begin
            acc_q[s1_ch_q] <= res;
        end
    end

endmodule

// File: tb/tb_mac_pipe_acc.sv
// Self-checking bench for mac_pipe_acc: vector table, corner-case sequences
// and randomized traffic against an arithmetic reference model.
module tb_mac_pipe_acc;

    localparam int IN_W     = 8;
    localparam int OUT_W    = 16;
    localparam int CHANNELS = 4;
    localparam int CH_W     = 2;

`ifdef SATURATE_EN
    localparam logic [15:0] BIG_RES  = 16'd65535;
    localparam logic [15:0] WRAP_RES = 16'd65535;
`else
    localparam logic [15:0] BIG_RES  = 16'd65024;
    localparam logic [15:0] WRAP_RES = 16'd0;
`endif

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [CH_W-1:0]  in_ch;
    logic             in_mode;
    logic             in_clr;
    logic [IN_W-1:0]  A;
    logic [IN_W-1:0]  B;
    logic [OUT_W-1:0] C;
    logic             acc_clr_all;
    logic             out_valid;
    logic             out_ready;
    logic [CH_W-1:0]  out_ch;
    logic [OUT_W-1:0] data_out;
    logic             out_ovf;

    mac_pipe_acc #(
        .IN_W(IN_W),
        .OUT_W(OUT_W),
        .CHANNELS(CHANNELS)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_ch(in_ch),
        .in_mode(in_mode),
        .in_clr(in_clr),
        .A(A),
        .B(B),
        .C(C),
        .acc_clr_all(acc_clr_all),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_ch(out_ch),
        .data_out(data_out),
        .out_ovf(out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] d;
        logic [1:0]  ch;
        logic        ovf;
    } res_t;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] c;
        logic [1:0]  ch;
        logic [15:0] ed;
        logic        eo;
    } vec_t;

    res_t        expq[$];
    logic [15:0] macc[CHANNELS];
    vec_t        tbl[6];
    int          checks;
    int          errors;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic model_beat(input logic md, input logic cl, input logic [1:0] ch,
                              input logic [7:0] a, input logic [7:0] b, input logic [15:0] c);
        logic [16:0] s;
        logic [15:0] base;
        res_t r;
        base = md ? (cl ? 16'd0 : macc[ch]) : c;
        s = 17'(a) * 17'(b) + {1'b0, base};
`ifdef SATURATE_EN
        r.d = s[16] ? 16'hFFFF : s[15:0];
`else
        r.d = s[15:0];
`endif
        r.ovf = s[16];
        r.ch  = ch;
        if (md) macc[ch] = r.d;
        expq.push_back(r);
    endtask

    task automatic cyc(input logic v, input logic md, input logic cl, input logic [1:0] ch,
                       input logic [7:0] a, input logic [7:0] b, input logic [15:0] c,
                       input logic ordy, input logic rst, input logic clra,
                       output logic acc, output logic got, output logic [15:0] gd);
        res_t e;
        in_valid    = v;
        in_mode     = md;
        in_clr      = cl;
        in_ch       = ch;
        A           = a;
        B           = b;
        C           = c;
        out_ready   = ordy;
        reset       = rst;
        acc_clr_all = clra;
        #1;
        acc = in_valid && in_ready;
        got = out_valid && out_ready;
        gd  = data_out;
        if (acc) model_beat(md, cl, ch, a, b, c);
        if (got) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got data %0d expected no output", data_out);
            end else begin
                e = expq.pop_front();
                chk("sb_data", data_out, e.d);
                chk("sb_ch", out_ch, e.ch);
                chk("sb_ovf", out_ovf, e.ovf);
            end
        end
        @(posedge clk);
        #1;
        if (rst) begin
            expq.delete();
            for (int i = 0; i < CHANNELS; i++) macc[i] = '0;
        end
        if (clra) begin
            for (int i = 0; i < CHANNELS; i++) macc[i] = '0;
        end
    endtask

    logic        acc_f;
    logic        got_f;
    logic [15:0] gd_f;

    task automatic idle(input logic ordy);
        cyc(0, 0, 0, 0, 0, 0, 0, ordy, 0, 0, acc_f, got_f, gd_f);
    endtask

    task automatic beat_d(input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] c, input logic [1:0] ch);
        cyc(1, 0, 0, ch, a, b, c, 1, 0, 0, acc_f, got_f, gd_f);
    endtask

    task automatic beat_a(input logic [1:0] ch, input logic [7:0] a,
                          input logic [7:0] b, input logic cl);
        cyc(1, 1, cl, ch, a, b, 0, 1, 0, 0, acc_f, got_f, gd_f);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] hold_d;
        logic [1:0]  hold_c;
        checks = 0;
        errors = 0;
        for (int i = 0; i < CHANNELS; i++) macc[i] = '0;

        tbl[0] = '{a: 8'd3,   b: 8'd4,   c: 16'd5,     ch: 2'd1, ed: 16'd17,    eo: 1'b0};
        tbl[1] = '{a: 8'd255, b: 8'd255, c: 16'd65535, ch: 2'd2, ed: BIG_RES,   eo: 1'b1};
        tbl[2] = '{a: 8'd0,   b: 8'd0,   c: 16'd0,     ch: 2'd0, ed: 16'd0,     eo: 1'b0};
        tbl[3] = '{a: 8'd255, b: 8'd255, c: 16'd0,     ch: 2'd3, ed: 16'd65025, eo: 1'b0};
        tbl[4] = '{a: 8'd1,   b: 8'd1,   c: 16'd65535, ch: 2'd0, ed: WRAP_RES,  eo: 1'b1};
        tbl[5] = '{a: 8'd16,  b: 8'd16,  c: 16'd100,   ch: 2'd2, ed: 16'd356,   eo: 1'b0};

        reset = 1'b1; in_valid = 0; in_mode = 0; in_clr = 0; in_ch = 0;
        A = 0; B = 0; C = 0; acc_clr_all = 0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_out_ch", out_ch, 0);
        chk("rst_out_ovf", out_ovf, 0);
        reset = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1);

        // Vector table: direct beats, latency and flags.
        for (int i = 0; i < 6; i++) begin
            beat_d(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].ch);
            chk("tbl_lat1", out_valid, 0);
            idle(1);
            chk("tbl_lat2", out_valid, 1);
            chk("tbl_data", data_out, tbl[i].ed);
            chk("tbl_ch", out_ch, tbl[i].ch);
            chk("tbl_ovf", out_ovf, tbl[i].eo);
        end
        idle(1);

        // Three back-to-back accumulates on ch2.
        beat_a(2, 10, 10, 1);
        beat_a(2, 10, 10, 0);
        beat_a(2, 10, 10, 0);
        chk("acc2_r1_got", got_f, 1); chk("acc2_r1", gd_f, 100);
        idle(1);
        chk("acc2_r2_got", got_f, 1); chk("acc2_r2", gd_f, 200);
        idle(1);
        chk("acc2_r3_got", got_f, 1); chk("acc2_r3", gd_f, 300);

        // Interleaved ch0 / ch1 accumulates.
        beat_a(0, 1, 2, 1);
        beat_a(1, 3, 3, 1);
        beat_a(0, 1, 2, 0);
        chk("il_r1", gd_f, 2);
        beat_a(1, 3, 3, 0);
        chk("il_r2", gd_f, 9);
        idle(1);
        chk("il_r3", gd_f, 4);
        idle(1);
        chk("il_r4", gd_f, 18);
        idle(1);

        // Backpressure with two beats in flight.
        beat_d(2, 3, 0, 1);
        beat_d(7, 1, 0, 2);
        hold_d = data_out;
        hold_c = out_ch;
        chk("bp_first", hold_d, 6);
        for (int k = 0; k < 3; k++) begin
            cyc(1, 0, 0, 3, 9, 9, 0, 0, 0, 0, acc_f, got_f, gd_f);
            chk("bp_in_ready", acc_f, 0);
            chk("bp_valid", out_valid, 1);
            chk("bp_hold_d", data_out, hold_d);
            chk("bp_hold_ch", out_ch, hold_c);
        end
        idle(1);
        chk("bp_rel1", gd_f, 6);
        idle(1);
        chk("bp_rel2_got", got_f, 1); chk("bp_rel2", gd_f, 7);
        idle(1);
        chk("bp_no_dup", got_f, 0);
        chk("bp_q_empty", expq.size(), 0);

        // Reset drops in-flight beats and clears accumulators.
        beat_a(3, 5, 10, 1);
        idle(1);
        idle(1);
        chk("rs_acc50", gd_f, 50);
        beat_a(3, 1, 1, 0);
        beat_a(3, 1, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, acc_f, got_f, gd_f);
        chk("rs_valid0", out_valid, 0);
        idle(1);
        chk("rs_bubble1", out_valid, 0);
        idle(1);
        chk("rs_bubble2", out_valid, 0);
        beat_a(3, 1, 1, 0);
        idle(1);
        idle(1);
        chk("rs_after", gd_f, 1);

        // Global clear colliding with a stage-2 accumulate write.
        beat_a(1, 3, 3, 1);
        idle(1);
        idle(1);
        chk("ca_first", gd_f, 9);
        beat_a(1, 1, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, acc_f, got_f, gd_f);
        idle(1);
        chk("ca_old_value", gd_f, 10);
        beat_a(1, 1, 1, 0);
        idle(1);
        idle(1);
        chk("ca_cleared", gd_f, 1);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            cyc(($urandom % 4) != 0, $urandom % 2, ($urandom % 5) == 0,
                2'($urandom % 4), 8'($urandom), 8'($urandom), 16'($urandom),
                ($urandom % 4) != 0, 0, 0, acc_f, got_f, gd_f);
        end
        for (int n = 0; n < 20 && expq.size() != 0; n++) idle(1);
        chk("rnd_drain", expq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
